// File: rtl/dmem_bridge_pkg.sv
// Shared types for the M-stage data-memory bus bridge: FSM states, the write-buffer
// entry layout and the data returned when a read times out.
package dmem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DONE
  } state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [29:0] tag;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store FIFO: entries stay resident and searchable until the bus accepts them.
// Lookup returns the youngest entry whose word tag matches.
module wbuf_fifo
  import dmem_bridge_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        push_i,
  input  wbuf_entry_t entry_i,
  input  logic        pop_i,
  input  logic [29:0] lookup_tag_i,
  output logic        full_o,
  output logic        empty_o,
  output wbuf_entry_t head_o,
  output logic        hit_o,
  output logic [31:0] hit_data_o
);

  // Pointers carry one extra bit so that full and empty differ.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW-1:0] count;
  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
    return IW'(p % PW'(DEPTH));
  endfunction

  assign count   = wptr_q - rptr_q;
  assign full_o  = (count == PW'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[slot(rptr_q)];

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i) < count) begin
        idx = slot(rptr_q + PW'(i));
        if (mem_q[idx].tag == lookup_tag_i) begin
          hit_o      = 1'b1;
          hit_data_o = mem_q[idx].data;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PW'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i && !full_o) mem_q[slot(wptr_q)] <= entry_i;
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// M-stage bridge to a single-port wait-stated data bus: posted stores with load
// forwarding, blocking load misses, and a sticky read-timeout error.
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WDM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErr,
  // Bus request handshake: a request transfers on a cycle with valid && ready; once
  // valid is raised, valid/we/addr/wdata hold until that cycle. Responses are
  // single-cycle pulses and are only honoured while waiting for a read.
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output state_e      dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;

  logic          hit, full, empty, push, pop, load_miss;
  logic [31:0]   hit_data;
  wbuf_entry_t   head, new_entry;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^ALUOutM[1:0];

  assign new_entry = '{tag: ALUOutM[31:2], data: WDM};
  assign push      = MemWriteM && !full;
  assign pop       = (state_q == ST_WR_REQ) && bus_req_ready;
  assign load_miss = MemtoRegM && !hit;

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .CLK          (CLK),
    .Reset        (Reset),
    .push_i       (push),
    .entry_i      (new_entry),
    .pop_i        (pop),
    .lookup_tag_i (ALUOutM[31:2]),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  // full is the registered occupancy, so a same-cycle pop does not release the store.
  assign StallM    = (load_miss && state_q != ST_RD_DONE) || (MemWriteM && full);
  assign ReadDataM = (state_q == ST_RD_DONE) ? rdata_q :
                     hit                     ? hit_data : rdata_q;
  assign BusErr      = bus_err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    bus_err_d     = bus_err_q;
    bus_req_valid = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_wdata     = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_miss)   state_d = ST_RD_REQ;
        else if (!empty) state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        bus_req_valid = 1'b1;
        bus_we        = 1'b1;
        bus_addr      = {head.tag, 2'b00};
        bus_wdata     = head.data;
        if (bus_req_ready) state_d = load_miss ? ST_RD_REQ : ST_IDLE;
      end
      ST_RD_REQ: begin
        // M is frozen while stalled, so ALUOutM is stable for the whole request.
        bus_req_valid = 1'b1;
        bus_addr      = {ALUOutM[31:2], 2'b00};
        if (bus_req_ready) begin
          state_d = ST_RD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (bus_rsp_valid) begin
          rdata_d = bus_rdata;
          state_d = ST_RD_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d   = BUS_ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = ST_RD_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Memory-stage bridge between the pipelined core's M stage and an external single-port data bus with variable wait states. Stores are posted into a small write buffer, and loads that hit the buffer are forwarded from it. Load misses issue a bus read and hold the pipeline on `StallM` until data returns. The block replaces the zero-latency data memory. `StallM` feeds the hazard unit, which freezes F/D/E/M while it is high.

## Interface
**Parameters**
- `WBUF_DEPTH`, 2 — write-buffer entries (power of two, ≥1).
- `TIMEOUT`, 255 — maximum cycles waiting for a read response before error.

**Ports**
- `CLK` in 1 — clock.
- `Reset` in 1 — reset, asynchronous, active-high.
- `ALUOutM` in 32 — M-stage address; only `[31:2]` is used (word access).
- `WDM` in 32 — M-stage store data.
- `MemWriteM` in 1 — M-stage store.
- `MemtoRegM` in 1 — M-stage load.
- `ReadDataM` out 32 — load result to the M/W register.
- `StallM` out 1 — pipeline hold request.
- `BusErr` out 1 — sticky read-timeout flag.
- `bus_req_valid` out 1 — request valid.
- `bus_req_ready` in 1 — request accepted when valid && ready.
- `bus_addr` out 32 — word address, with `[1:0]` driven as 0.
- `bus_wdata` out 32 — write data.
- `bus_we` out 1 — 1 = write, 0 = read.
- `bus_rsp_valid` in 1 — one-cycle read response pulse.
- `bus_rdata` in 32 — read data, valid with `bus_rsp_valid`.

## Operation
**States:** IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.

**Write buffer (FIFO)**
- Push when `MemWriteM && !full`, entry = {`ALUOutM[31:2]`, `WDM`}.
- Pop when a bus write is accepted in WR_REQ.
- An entry stays resident, and visible to lookup, until it is accepted.

**Lookup**
- `hit` = some valid entry has a tag equal to `ALUOutM[31:2]`.
- On a hit, the youngest matching entry supplies `ReadDataM` combinationally.

**StallM (combinational)**
- `StallM = (MemtoRegM && !hit && state != RD_DONE) || (MemWriteM && full)`.
- A pop in the same cycle does not relieve the full condition.

**State transitions**
- **IDLE**
  - Load miss → RD_REQ, with the read taking priority over draining.
  - Otherwise, buffer non-empty → WR_REQ, driving the head entry.
- **WR_REQ**
  - Hold `bus_req_valid`=1, `bus_we`=1, and address/data stable until accepted.
  - On accept: pop the entry, then go to RD_REQ if a load miss is pending, otherwise IDLE.
- **RD_REQ**
  - Drive `bus_req_valid`=1, `bus_we`=0, address = `ALUOutM`, held stable because M is stalled.
  - On accept → RD_WAIT and clear the timeout counter.
- **RD_WAIT**
  - `bus_req_valid`=0; the counter increments each cycle.
  - On `bus_rsp_valid`: capture `bus_rdata` → RD_DONE.
  - If the counter reaches `TIMEOUT` first: capture 32'hDEADBEEF, set `BusErr` → RD_DONE.
- **RD_DONE**
  - `StallM`=0 and `ReadDataM` = captured register; the load advances at this edge.
  - Next state is always IDLE; no new request is issued for this load.

**Other rules**
- A `bus_rsp_valid` outside RD_WAIT is ignored.
- Only one bus transaction is outstanding at a time.
- `ReadDataM` mux priority: RD_DONE register, then buffer hit, then the captured register (don't-care).

## Timing
- **Reset values:** state IDLE, buffer empty, `StallM` 0, `ReadDataM` 0, `BusErr` 0, `bus_req_valid` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0.
- **Reset mid-transaction:** abandons the transaction immediately and discards buffered stores.
- **Store, buffer not full:** 0 stall cycles.
- **Load hit:** 0 stall cycles.
- **Load miss with immediate ready and response latency L (≥1 cycle after accept):** stall = L+2 cycles (RD_REQ, L×RD_WAIT, then advance in RD_DONE).
- **Load miss behind an in-flight write:** adds the write's wait cycles.
- **Stores and `bus_req_ready`:** a push and an accept in the same cycle are both performed.
- **Full buffer:** a store in M is stalled and is pushed on the edge after the pop.
- **Wrap-around:** FIFO pointers carry one extra bit so full and empty are distinguishable.
- **`BusErr`:** stays set until `Reset`.

## Structure
- **Package `dmem_bridge_pkg`:**
  - state enum;
  - `BUS_ERR_DATA` = 32'hDEADBEEF;
  - write-buffer entry struct {tag[29:0], data[31:0]}.
- **Sub-module `wbuf_fifo`:**
  - FIFO with push/pop and full/empty;
  - youngest-match tag lookup producing `hit` and data.
- **Top level:** FSM, timeout counter and the `StallM`/`ReadDataM` muxing.

## Test plan
- **Store then load, same address:** store 0x100←0x12345678 with `bus_req_ready`=0, then load 0x100 → `StallM` stays 0 and `ReadDataM`=0x12345678.
- **Load miss:** load 0x200, ready=1, response 3 cycles after accept with 0xCAFEF00D → `StallM` high for 5 cycles and `ReadDataM`=0xCAFEF00D in RD_DONE.
- **Full buffer (DEPTH=2):** ready=0 and three stores → the third sees `StallM`=1; raise ready → the third store is pushed the edge after the first accept, and bus writes leave in order.
- **Read waits for write:** store 0x10 in flight (ready=0), then load miss 0x20 → read issued only after the write is accepted, and `bus_addr` stays stable while waiting.
- **Timeout:** load miss with `bus_rsp_valid` never asserted → `ReadDataM`=0xDEADBEEF after 255 wait cycles and `BusErr`=1 sticky.
- **Reset mid-read:** assert `Reset` in RD_WAIT → all outputs return to reset values and the buffer is empty.
